button_input: RTL and testbench

- Input-side counterpart of the board LED status driver: turns raw board push-buttons into clean game control events.
- Synchronises and debounces the throw, left and right buttons.
- Runs a throw-charge state machine: holding throw builds up power; releasing it fires the throw.
- Produces single-cycle event pulses and a registered power value for the game logic. Sits between the top-level pins and the game FSM.

---
 rtl/button_input_pkg.sv | 16 +
 rtl/button_input_if.sv | 26 ++
 rtl/button_input_btn_debounce.sv | 48 ++++
 rtl/button_input.sv | 133 +++++++++++++
 tb/tb_button_input.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/button_input_pkg.sv
// Shared game package: throw FSM state encoding and 60 MHz derived timing constants.
package button_input_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHARGE = 2'd1,
        FIRE   = 2'd2
    } throw_state_e;

    localparam int unsigned CLK_HZ              = 60_000_000;
    localparam int unsigned DEF_POWER_W         = 7;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
    localparam int unsigned DEF_POWER_TICK      = CLK_HZ / 200;  // 5 ms per power step
    localparam int unsigned DEF_REPEAT_CYCLES   = CLK_HZ / 4;    // 250 ms autorepeat

endpackage

// File: rtl/button_input_if.sv
// Board-button / game-logic bundle: raw buttons and turn enable in, control events out.
interface button_input_if
    import button_input_pkg::*;
#(
    parameter int unsigned POWER_W = DEF_POWER_W
);
    logic               btn_throw;
    logic               btn_left;
    logic               btn_right;
    logic               enable;
    logic               throw_pulse;
    logic [POWER_W-1:0] throw_power;
    logic               charging;
    logic               left_pulse;
    logic               right_pulse;

    modport master (
        output btn_throw, btn_left, btn_right, enable,
        input  throw_pulse, throw_power, charging, left_pulse, right_pulse
    );

    modport slave (
        input  btn_throw, btn_left, btn_right, enable,
        output throw_pulse, throw_power, charging, left_pulse, right_pulse
    );
endinterface

// File: rtl/button_input_btn_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stability counter, debounced level
// with registered single-cycle rise/fall strobes aligned to the level change.
module btn_debounce
    import button_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk60MHz,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Strobes are produced on the flip edge itself so they line up with the new level.
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= ~level;
                rise  <= ~level;
                fall  <= level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_input.sv
// Button front end: debounces throw/left/right and runs the throw-charge FSM.
// Define BUTTON_AUTOREPEAT_EN to get periodic repeat pulses while a move button is held.
module button_input
    import button_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned POWER_W         = DEF_POWER_W,
    parameter int unsigned POWER_TICK      = DEF_POWER_TICK,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic          clk60MHz,
    input  logic          rst,
    button_input_if.slave bus
);
    localparam int unsigned TICK_W = (POWER_TICK > 1) ? $clog2(POWER_TICK) : 1;

    throw_state_e       state, state_nx;
    logic               thr_lvl, thr_rise, thr_fall;
    logic               l_lvl, l_rise, l_fall;
    logic               r_lvl, r_rise, r_fall;
    logic [POWER_W-1:0] acc, power_q;
    logic [TICK_W-1:0]  tick;
    logic               throw_pulse_q, charging_q, left_q, right_q;
    logic               throw_pulse_nx, charging_nx, left_nx, right_nx;
    logic               move_ok, rpt_left, rpt_right;
    logic               unused_ok;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_throw (
        .clk60MHz(clk60MHz), .rst(rst), .btn(bus.btn_throw),
        .level(thr_lvl), .rise(thr_rise), .fall(thr_fall)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk60MHz(clk60MHz), .rst(rst), .btn(bus.btn_left),
        .level(l_lvl), .rise(l_rise), .fall(l_fall)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk60MHz(clk60MHz), .rst(rst), .btn(bus.btn_right),
        .level(r_lvl), .rise(r_rise), .fall(r_fall)
    );

    assign move_ok = bus.enable && (state == IDLE);

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nx;
    logic             hold_one, rpt_hit;

    // Counter restarts on the initial edge so repeats are spaced from the first pulse.
    always_comb begin
        hold_one   = move_ok && (l_lvl ^ r_lvl);
        rpt_hit    = 1'b0;
        rpt_cnt_nx = '0;
        if (hold_one && !l_rise && !r_rise) begin
            if (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1)) rpt_hit = 1'b1;
            else                                      rpt_cnt_nx = rpt_cnt + RPT_W'(1);
        end
    end

    always_ff @(posedge clk60MHz) begin
        if (rst) rpt_cnt <= '0;
        else     rpt_cnt <= rpt_cnt_nx;
    end

    assign rpt_left  = rpt_hit && l_lvl;
    assign rpt_right = rpt_hit && r_lvl;
    assign unused_ok = ^{thr_lvl, l_fall, r_fall};
`else
    assign rpt_left  = 1'b0;
    assign rpt_right = 1'b0;
    assign unused_ok = ^{thr_lvl, l_fall, r_fall, l_lvl, r_lvl, REPEAT_CYCLES};
`endif

    always_ff @(posedge clk60MHz) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Abort on enable drop wins over a same-cycle release.
    always_comb begin
        state_nx       = state;
        throw_pulse_nx = 1'b0;
        charging_nx    = 1'b0;
        left_nx        = 1'b0;
        right_nx       = 1'b0;
        case (state)
            IDLE:    if (thr_rise && bus.enable) state_nx = CHARGE;
            CHARGE:  if (!bus.enable)            state_nx = IDLE;
                     else if (thr_fall)          state_nx = FIRE;
            FIRE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        throw_pulse_nx = (state_nx == FIRE);
        charging_nx    = (state_nx == CHARGE);
        left_nx        = (move_ok && l_rise && !r_rise) || rpt_left;
        right_nx       = (move_ok && r_rise && !l_rise) || rpt_right;
    end

    // Accumulator sits at zero outside CHARGE, so every charge starts from a clean slate.
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            acc           <= '0;
            tick          <= '0;
            power_q       <= '0;
            throw_pulse_q <= 1'b0;
            charging_q    <= 1'b0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
        end else begin
            throw_pulse_q <= throw_pulse_nx;
            charging_q    <= charging_nx;
            left_q        <= left_nx;
            right_q       <= right_nx;
            if (state != CHARGE) begin
                acc  <= '0;
                tick <= '0;
            end else if (tick == TICK_W'(POWER_TICK - 1)) begin
                tick <= '0;
                if (acc != '1) acc <= acc + POWER_W'(1);
            end else begin
                tick <= tick + TICK_W'(1);
            end
            if (state_nx == FIRE) power_q <= acc;
        end
    end

    assign bus.throw_pulse = throw_pulse_q;
    assign bus.throw_power = power_q;
    assign bus.charging    = charging_q;
    assign bus.left_pulse  = left_q;
    assign bus.right_pulse = right_q;

endmodule

// File: tb/tb_button_input.sv
// Directed bench for button_input with an event scoreboard popped on every output pulse.
module tb_button_input;
    localparam int unsigned DB = 4;
    localparam int unsigned PT = 2;
    localparam int unsigned PW = 3;
    localparam int unsigned RC = 8;
    localparam int unsigned LAT = DB + 3;

    typedef struct packed {
        logic [2:0]    pulses;  // {throw, left, right}
        logic [PW-1:0] power;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_input_if #(.POWER_W(PW)) bus ();

    button_input #(
        .DEBOUNCE_CYCLES(DB), .POWER_W(PW), .POWER_TICK(PT), .REPEAT_CYCLES(RC)
    ) dut (
        .clk60MHz(clk),
        .rst     (rst),
        .bus     (bus)
    );

    exp_t          sb[$];
    exp_t          got;
    logic [2:0]    obs_pulses;
    logic [PW-1:0] last_power = '0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input logic [2:0] p, input logic [PW-1:0] pw);
        exp_t e;
        e.pulses = p;
        e.power  = pw;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_throw_pulse"}, 32'(bus.throw_pulse), 32'(0));
        chk({tag, "_throw_power"}, 32'(bus.throw_power), 32'(0));
        chk({tag, "_charging"},    32'(bus.charging),    32'(0));
        chk({tag, "_left_pulse"},  32'(bus.left_pulse),  32'(0));
        chk({tag, "_right_pulse"}, 32'(bus.right_pulse), 32'(0));
    endtask

    // Every observed pulse must match the oldest outstanding expected event.
    always @(negedge clk) begin
        obs_pulses = {bus.throw_pulse, bus.left_pulse, bus.right_pulse};
        if (!rst && obs_pulses != 3'b000) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'(obs_pulses), 32'(0));
            end else begin
                got = sb.pop_front();
                chk("event_kind",  32'(obs_pulses),      32'(got.pulses));
                chk("event_power", 32'(bus.throw_power), 32'(got.power));
            end
        end
    end

    initial begin
        bus.btn_throw = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.enable    = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        chk_all_zero("reset");

        bus.enable = 1'b1;

        // Short glitch on left is filtered.
        bus.btn_left = 1'b1;
        step(3);
        bus.btn_left = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("glitch_left", 32'(bus.left_pulse), 32'(0));
        end

        // Clean left press: single pulse exactly LAT cycles after the raw rise.
        bus.btn_left = 1'b1;
        expect_evt(3'b010, last_power);
        for (int i = 1; i <= LAT; i++) begin
            step(1);
            chk("left_latency", 32'(bus.left_pulse), 32'(i == LAT));
        end
        bus.btn_left = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("left_single", 32'(bus.left_pulse), 32'(0));
        end

        // Clean right press.
        bus.btn_right = 1'b1;
        expect_evt(3'b001, last_power);
        for (int i = 1; i <= LAT; i++) begin
            step(1);
            chk("right_latency", 32'(bus.right_pulse), 32'(i == LAT));
        end
        bus.btn_right = 1'b0;
        step(10);

        // Normal throw: 11 cycles in CHARGE with POWER_TICK=2 gives 5 ticks.
        bus.btn_throw = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            step(1);
            chk("charge_start", 32'(bus.charging), 32'(i == LAT));
        end
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("charging_hold", 32'(bus.charging), 32'(1));
        end
        bus.btn_throw = 1'b0;
        expect_evt(3'b100, PW'(5));
        for (int i = 1; i <= LAT; i++) begin
            step(1);
            chk("fire_pulse", 32'(bus.throw_pulse), 32'(i == LAT));
            if (i < LAT) chk("charging_release", 32'(bus.charging), 32'(1));
        end
        chk("throw_power_5",  32'(bus.throw_power), 32'(5));
        chk("charging_fire",  32'(bus.charging),    32'(0));
        last_power = PW'(5);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("power_hold", 32'(bus.throw_power), 32'(5));
        end

        // Long hold saturates at 2^PW-1.
        bus.btn_throw = 1'b1;
        step(LAT);
        chk("sat_charging", 32'(bus.charging), 32'(1));
        step(40);
        bus.btn_throw = 1'b0;
        expect_evt(3'b100, PW'(7));
        step(LAT);
        chk("sat_pulse", 32'(bus.throw_pulse), 32'(1));
        chk("sat_power", 32'(bus.throw_power), 32'(7));
        last_power = PW'(7);
        step(3);

        // Enable drop aborts the charge with no throw.
        bus.btn_throw = 1'b1;
        step(LAT);
        chk("abort_charging", 32'(bus.charging), 32'(1));
        step(3);
        bus.enable = 1'b0;
        step(1);
        chk("abort_idle",  32'(bus.charging),    32'(0));
        chk("abort_power", 32'(bus.throw_power), 32'(7));
        bus.btn_throw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("abort_no_pulse", 32'(bus.throw_pulse), 32'(0));
        end
        chk("abort_power_after", 32'(bus.throw_power), 32'(7));

        // Press while disabled does not start charging once enable returns.
        bus.btn_throw = 1'b1;
        step(10);
        bus.enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("disabled_press", 32'(bus.charging), 32'(0));
        end
        bus.btn_throw = 1'b0;
        step(10);

        // Left and right rising together cancel each other.
        bus.btn_left  = 1'b1;
        bus.btn_right = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("both_left",  32'(bus.left_pulse),  32'(0));
            chk("both_right", 32'(bus.right_pulse), 32'(0));
        end
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        step(10);

        // Held left: repeats every RC cycles only when autorepeat is built in.
        bus.btn_left = 1'b1;
        expect_evt(3'b010, last_power);
`ifdef BUTTON_AUTOREPEAT_EN
        for (int i = 0; i < 3; i++) expect_evt(3'b010, last_power);
`endif
        step(LAT);
        chk("hold_first", 32'(bus.left_pulse), 32'(1));
        for (int i = 1; i <= 36; i++) begin
            step(1);
`ifdef BUTTON_AUTOREPEAT_EN
            chk("hold_repeat", 32'(bus.left_pulse), 32'((i % RC) == 0 && i <= 3 * RC));
`else
            chk("hold_repeat", 32'(bus.left_pulse), 32'(0));
`endif
            if (i == 3 * RC) bus.btn_left = 1'b0;
        end
        step(5);

        // Reset during CHARGE clears everything with no throw.
        bus.btn_throw = 1'b1;
        step(LAT);
        chk("rst_charging", 32'(bus.charging), 32'(1));
        step(2);
        rst = 1'b1;
        bus.btn_throw = 1'b0;
        step(1);
        chk_all_zero("midcharge_reset");
        rst = 1'b0;
        last_power = '0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            chk("post_reset_pulse",    32'(bus.throw_pulse), 32'(0));
            chk("post_reset_charging", 32'(bus.charging),    32'(0));
        end

        step(2);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
